// File: rtl/blit_pkg.sv
// Shared constants, state encoding and pixel tag for the sprite blitter.
package blit_pkg;

    localparam int FB_W    = 240;
    localparam int FB_H    = 160;
    localparam int SRC_W   = 256;
    localparam int ADDR_W  = 19;
    localparam int COLOR_W = 24;
    localparam logic [COLOR_W-1:0] COLOR_KEY = 24'hFF00FF;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} blit_state_t;

    // Destination coordinates travel alongside the sheet read so the write
    // stage sees them in the same cycle as src_data.
    typedef struct packed {
        logic               vis;
        logic signed [10:0] dx;
        logic signed [10:0] dy;
    } pix_tag_t;

    // Row-major linear address, wraps at ADDR_W bits.
    function automatic logic [ADDR_W-1:0] lin_addr(input logic [ADDR_W-1:0] y,
                                                   input logic [ADDR_W-1:0] x,
                                                   input logic [ADDR_W-1:0] pitch);
        return y * pitch + x;
    endfunction

endpackage

// File: rtl/blit_scan_counter.sv
// Row-major col/row scan over a W x H sprite with a last-pixel flag.
// With BLIT_MIRROR_EN defined, col_src runs right-to-left when mirror is set.
module blit_scan_counter
    import blit_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       clear,
    input  logic       en,
    input  logic [7:0] w,
    input  logic [7:0] h,
`ifdef BLIT_MIRROR_EN
    input  logic       mirror,
`endif
    output logic [7:0] col,
    output logic [7:0] row,
    output logic [7:0] col_src,
    output logic       last
);

    logic col_end;

    assign col_end = (col == w - 8'd1);
    assign last    = col_end && (row == h - 8'd1);

`ifdef BLIT_MIRROR_EN
    assign col_src = mirror ? (w - 8'd1 - col) : col;
`else
    assign col_src = col;
`endif

    // Advance one pixel per enabled cycle; clear restarts at the top-left.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            col <= '0;
            row <= '0;
        end else if (clear) begin
            col <= '0;
            row <= '0;
        end else if (en) begin
            if (col_end) begin
                col <= '0;
                row <= row + 8'd1;
            end else begin
                col <= col + 8'd1;
            end
        end
    end

endmodule

// File: rtl/sprite_blitter.sv
// Sprite blitter: copies a W x H sprite from the sheet RAM into the
// framebuffer at one pixel per clock, dropping colour-key and off-screen
// pixels. Optional horizontal mirroring is built only with BLIT_MIRROR_EN.
module sprite_blitter
    import blit_pkg::*;
(
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               start,
    input  logic [8:0]         src_x,
    input  logic [8:0]         src_y,
    input  logic [7:0]         spr_w,
    input  logic [7:0]         spr_h,
    input  logic [9:0]         dst_x,
    input  logic [9:0]         dst_y,
    input  logic               flip_x,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  src_addr,
    input  logic [COLOR_W-1:0] src_data,
    output logic [ADDR_W-1:0]  fb_addr,
    output logic [COLOR_W-1:0] fb_data,
    output logic               fb_we
);

    localparam logic signed [10:0] FB_W_S = 11'(FB_W);
    localparam logic signed [10:0] FB_H_S = 11'(FB_H);

    blit_state_t state_q, state_d;
    logic        accept;
    logic [8:0]  src_x_q, src_y_q;
    logic [7:0]  w_q, h_q;
    logic [9:0]  dst_x_q, dst_y_q;
    logic [7:0]  col, row, col_src;
    logic        last;
    logic        issue_vld, wr_vld;
    pix_tag_t    issue_tag, wr_tag;

    assign accept    = (state_q == IDLE) && start;
    assign issue_vld = (state_q == RUN);

`ifdef BLIT_MIRROR_EN
    logic flip_q;

    // Mirror request is sampled with the rest of the blit parameters.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)    flip_q <= 1'b0;
        else if (accept) flip_q <= flip_x;
    end
`else
    logic unused_flip;
    assign unused_flip = flip_x;
`endif

    // Blit parameters are captured once per accepted start and held.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            src_x_q <= '0;
            src_y_q <= '0;
            w_q     <= '0;
            h_q     <= '0;
            dst_x_q <= '0;
            dst_y_q <= '0;
        end else if (accept) begin
            src_x_q <= src_x;
            src_y_q <= src_y;
            w_q     <= spr_w;
            h_q     <= spr_h;
            dst_x_q <= dst_x;
            dst_y_q <= dst_y;
        end
    end

    blit_scan_counter u_scan (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .clear   (accept),
        .en      (issue_vld),
        .w       (w_q),
        .h       (h_q),
`ifdef BLIT_MIRROR_EN
        .mirror  (flip_q),
`endif
        .col     (col),
        .row     (row),
        .col_src (col_src),
        .last    (last)
    );

    // FSM state register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next state. An empty sprite still passes through DRAIN so done lands
    // two cycles after start, matching the W*H+2 rule for the W*H=0 case.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (spr_w == 8'd0 || spr_h == 8'd0) ? DRAIN : RUN;
            RUN:     if (last)  state_d = DRAIN;
            DRAIN:   state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy = (state_q == RUN) || (state_q == DRAIN);
        done = (state_q == FIN);
    end

    // Issue stage: sheet read address and destination tag for the current pixel.
    always_comb begin
        src_addr = '0;
        if (issue_vld)
            src_addr = lin_addr(ADDR_W'(src_y_q) + ADDR_W'(row),
                                ADDR_W'(src_x_q) + ADDR_W'(col_src),
                                ADDR_W'(SRC_W));
        issue_tag.dx  = $signed({dst_x_q[9], dst_x_q}) + $signed({3'b000, col});
        issue_tag.dy  = $signed({dst_y_q[9], dst_y_q}) + $signed({3'b000, row});
        issue_tag.vis = (issue_tag.dx >= 11'sd0) && (issue_tag.dx < FB_W_S) &&
                        (issue_tag.dy >= 11'sd0) && (issue_tag.dy < FB_H_S);
    end

    // One-stage tag pipeline to line up with the sheet's read latency.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_vld <= 1'b0;
            wr_tag <= '0;
        end else begin
            wr_vld <= issue_vld;
            wr_tag <= issue_tag;
        end
    end

    // Write stage: outputs are held at zero whenever no pixel is in flight.
    always_comb begin
        fb_we   = wr_vld && wr_tag.vis && (src_data != COLOR_KEY);
        fb_addr = '0;
        fb_data = '0;
        if (wr_vld) begin
            fb_addr = lin_addr(ADDR_W'($unsigned(wr_tag.dy)),
                               ADDR_W'($unsigned(wr_tag.dx)),
                               ADDR_W'(FB_W));
            fb_data = src_data;
        end
    end

endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench for sprite_blitter: directed vector table, random
// blits against a pixel-list reference model, and a mid-blit reset.
module tb_sprite_blitter;

    localparam logic [23:0] KEY = 24'hFF00FF;

    typedef struct {
        int sx, sy, w, h, dx, dy;
        bit flip;
        bit poke;
        int exp_wr;
        int exp_done;
    } vec_t;

    typedef struct {
        int k;
        int addr;
        int data;
    } wr_t;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b1;
    logic        start = 1'b0;
    logic [8:0]  src_x = '0, src_y = '0;
    logic [7:0]  spr_w = '0, spr_h = '0;
    logic [9:0]  dst_x = '0, dst_y = '0;
    logic        flip_x = 1'b0;
    logic        busy, done, fb_we;
    logic [18:0] src_addr, fb_addr;
    logic [23:0] src_data, fb_data;

    int n_chk = 0;
    int n_pass = 0;
    logic [23:0] sheet_ovr [int];
    wr_t exp_q [$];

    sprite_blitter dut (
        .Clk(Clk), .Reset_n(Reset_n), .start(start),
        .src_x(src_x), .src_y(src_y), .spr_w(spr_w), .spr_h(spr_h),
        .dst_x(dst_x), .dst_y(dst_y), .flip_x(flip_x),
        .busy(busy), .done(done), .src_addr(src_addr), .src_data(src_data),
        .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we)
    );

    always #5 Clk = ~Clk;

    function automatic logic [23:0] sheet_word(input int a);
        if (sheet_ovr.exists(a)) return sheet_ovr[a];
        if (a % 11 == 3) return KEY;
        return 24'(a * 40503 + 12345) ^ 24'h5A5A5A;
    endfunction

    // Sheet RAM: fixed one-cycle read latency.
    always @(posedge Clk) src_data <= sheet_word(int'(src_addr));

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference: list of (cycle offset, fb address, data) in scan order.
    function automatic void build_expect(input vec_t v);
        bit mir;
        int sc, a, x, y;
        logic [23:0] d;
`ifdef BLIT_MIRROR_EN
        mir = v.flip;
`else
        mir = 1'b0;
`endif
        exp_q.delete();
        for (int r = 0; r < v.h; r++)
            for (int c = 0; c < v.w; c++) begin
                sc = mir ? (v.w - 1 - c) : c;
                a  = ((v.sy + r) * 256 + v.sx + sc) & 'h7FFFF;
                d  = sheet_word(a);
                x  = v.dx + c;
                y  = v.dy + r;
                if (x >= 0 && x < 240 && y >= 0 && y < 160 && d != KEY)
                    exp_q.push_back('{k: r * v.w + c + 2, addr: y * 240 + x, data: int'(d)});
            end
    endfunction

    // Launch a blit at the current negedge and watch it to completion.
    task automatic run_blit(input int vi, input vec_t v);
        int got_done, done_cnt, n_wr, busy_bad, wh;
        wr_t e;
        wh = v.w * v.h;
        build_expect(v);
        src_x = 9'(v.sx); src_y = 9'(v.sy);
        spr_w = 8'(v.w);  spr_h = 8'(v.h);
        dst_x = 10'(v.dx); dst_y = 10'(v.dy);
        flip_x = v.flip;
        start = 1'b1;
        got_done = -1; done_cnt = 0; n_wr = 0; busy_bad = 0;
        for (int k = 1; k <= wh + 5; k++) begin
            @(negedge Clk);
            if (fb_we) begin
                n_wr++;
                if (exp_q.size() == 0) begin
                    check($sformatf("v%0d_extra_write", vi), int'(fb_addr), -1);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("v%0d_wr_cycle", vi), k, e.k);
                    check($sformatf("v%0d_wr_addr", vi), int'(fb_addr), e.addr);
                    check($sformatf("v%0d_wr_data", vi), int'(fb_data), e.data);
                end
            end
            if (!(wh == 0 && k == 1) && (busy != (k <= wh + 1))) busy_bad++;
            if (done) begin
                done_cnt++;
                if (got_done < 0) got_done = k;
            end
            // Re-issued start while the blit is busy or finishing must be ignored.
            if (v.poke && k <= 2) begin
                start = 1'b1;
                spr_w = 8'd4; spr_h = 8'd4; dst_x = 10'd0; dst_y = 10'd0;
            end else begin
                start = 1'b0;
            end
        end
        check($sformatf("v%0d_done_cycle", vi), got_done, wh + 2);
        check($sformatf("v%0d_done_pulses", vi), done_cnt, 1);
        check($sformatf("v%0d_busy_window", vi), busy_bad, 0);
        check($sformatf("v%0d_missing_writes", vi), exp_q.size(), 0);
        if (v.exp_wr >= 0)   check($sformatf("v%0d_write_count", vi), n_wr, v.exp_wr);
        if (v.exp_done >= 0) check($sformatf("v%0d_done_table", vi), got_done, v.exp_done);
    endtask

    initial begin
        vec_t vecs [0:8];
        vec_t rv;
        int bad;

        // Directed sheet contents.
        sheet_ovr[0] = 24'h111111; sheet_ovr[1] = 24'h222222;
        sheet_ovr[256] = 24'h333333; sheet_ovr[257] = 24'h444444;
        for (int i = 0; i < 4; i++) sheet_ovr[5 * 256 + 10 + i] = 24'h0A0000 + 24'(i);
        sheet_ovr[5 * 256 + 11] = KEY;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) sheet_ovr[(100 + r) * 256 + 100 + c] = 24'h0B0000 + 24'(r * 4 + c);
        sheet_ovr[30 * 256 + 20] = 24'hA0A0A0;
        sheet_ovr[30 * 256 + 21] = 24'hB0B0B0;
        sheet_ovr[30 * 256 + 22] = 24'hC0C0C0;

        //            sx   sy   w   h   dx    dy  flip poke wr  done
        vecs[0] = '{  0,   0,   2,  2,    0,    0, 0, 0,  4,  6};
        vecs[1] = '{ 10,   5,   4,  1,   50,   20, 0, 0,  3,  6};
        vecs[2] = '{100, 100,   4,  4,   -2,  158, 0, 0,  4, 18};
        vecs[3] = '{  7,   7,   0,  3,   10,   10, 0, 1,  0,  2};
        vecs[4] = '{ 20,  30,   3,  1,    5,    5, 1, 0,  3,  5};
        vecs[5] = '{ 40,  40,   5,  4,  300,   10, 0, 0,  0, 22};
        vecs[6] = '{ 40,  40,   8,  2, -512,   10, 0, 0,  0, 18};
        vecs[7] = '{  0,   0,   2,  2,  239,  159, 0, 0,  1,  6};
        vecs[8] = '{ 60,  70,   3,  3,  230,  150, 0, 1, -1, 11};

        // Reset state.
        #2 Reset_n = 1'b0;
        @(negedge Clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_fb_we", int'(fb_we), 0);
        check("rst_src_addr", int'(src_addr), 0);
        check("rst_fb_addr", int'(fb_addr), 0);
        check("rst_fb_data", int'(fb_data), 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);

        for (int i = 0; i < 9; i++) run_blit(i, vecs[i]);

        // Mirror order spelled out for the 3x1 P,Q,R sprite.
        rv = vecs[4];
        build_expect(rv);
`ifdef BLIT_MIRROR_EN
        check("mirror_first_px", exp_q[0].data, 32'hC0C0C0);
`else
        check("mirror_first_px", exp_q[0].data, 32'hA0A0A0);
`endif

        // Random blits against the model.
        for (int i = 0; i < 12; i++) begin
            rv.sx = int'($urandom_range(0, 400));
            rv.sy = int'($urandom_range(0, 400));
            rv.w  = int'($urandom_range(0, 12));
            rv.h  = int'($urandom_range(0, 12));
            rv.dx = int'($urandom_range(0, 300)) - 30;
            rv.dy = int'($urandom_range(0, 210)) - 25;
            rv.flip = bit'($urandom_range(0, 1));
            rv.poke = bit'($urandom_range(0, 1));
            rv.exp_wr = -1;
            rv.exp_done = -1;
            run_blit(100 + i, rv);
        end

        // Reset in the middle of a 16x16 blit.
        rv = '{0, 0, 16, 16, 0, 0, 0, 0, -1, -1};
        src_x = '0; src_y = '0; spr_w = 8'd16; spr_h = 8'd16;
        dst_x = '0; dst_y = '0; flip_x = 1'b0;
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        repeat (40) @(negedge Clk);
        check("abort_pre_busy", int'(busy), 1);
        Reset_n = 1'b0;
        #1;
        check("abort_fb_we", int'(fb_we), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_src_addr", int'(src_addr), 0);
        check("abort_fb_addr", int'(fb_addr), 0);
        check("abort_fb_data", int'(fb_data), 0);
        bad = 0;
        repeat (3) begin
            @(negedge Clk);
            if (fb_we || busy || done) bad++;
        end
        Reset_n = 1'b1;
        repeat (3) begin
            @(negedge Clk);
            if (fb_we || busy || done) bad++;
        end
        check("abort_quiet", bad, 0);
        run_blit(200, vecs[0]);
        run_blit(201, rv);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
